// File: rtl/fp16_divider_if.sv
// rtl/fp16_divider_if.sv - operand/result handshake bundle for fp16_divider
interface fp16_divider_if;
  logic       in_valid;
  logic       in_ready;
  logic       Asign;
  logic       Bsign;
  logic [4:0] Aexp;
  logic [4:0] Bexp;
  logic [9:0] Amant;
  logic [9:0] Bmant;
  logic       out_valid;
  logic       out_ready;
  logic       FinalSign;
  logic [4:0] FinalExp;
  logic [9:0] FinalMant;
  logic       overflow;
  logic       divzero;

  modport master (
    output in_valid, Asign, Bsign, Aexp, Bexp, Amant, Bmant, out_ready,
    input  in_ready, out_valid, FinalSign, FinalExp, FinalMant, overflow, divzero
  );

  modport slave (
    input  in_valid, Asign, Bsign, Aexp, Bexp, Amant, Bmant, out_ready,
    output in_ready, out_valid, FinalSign, FinalExp, FinalMant, overflow, divzero
  );
endinterface

// File: rtl/fp16_divider.sv
// rtl/fp16_divider.sv - multi-cycle fp16 divider, 12-step restoring significand division
// Truncating results; denormals take hidden bit 1 like the companion adder.
module fp16_divider (
  input logic           clk,
  input logic           rst_n,
  fp16_divider_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] NORM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              sign;
  logic signed [6:0] e;
  logic [11:0]       rem;
  logic [10:0]       dvs;
  logic [11:0]       q;

  logic              a_zero, b_zero, a_spec, b_spec, s_in;
  logic signed [6:0] e_in;
  logic              spec_hit, spec_sign, spec_dz;
  logic [4:0]        spec_exp;
  logic [9:0]        spec_mant;
  logic              ge;
  logic [11:0]       r_next;
  logic signed [6:0] e_n;
  logic [9:0]        m_n;

  assign bus.in_ready = (state == IDLE) && rst_n;

  assign a_zero = (bus.Aexp == 5'd0) && (bus.Amant == 10'd0);
  assign b_zero = (bus.Bexp == 5'd0) && (bus.Bmant == 10'd0);
  assign a_spec = (bus.Aexp == 5'd31);
  assign b_spec = (bus.Bexp == 5'd31);
  assign s_in   = bus.Asign ^ bus.Bsign;
  assign e_in   = $signed({2'b00, bus.Aexp}) - $signed({2'b00, bus.Bexp}) + 7'sd15;

  // Special-operand resolution, highest precedence first.
  always_comb begin
    spec_hit  = 1'b1;
    spec_sign = s_in;
    spec_exp  = 5'd31;
    spec_mant = 10'd0;
    spec_dz   = 1'b0;
    if ((a_zero && b_zero) || (a_spec && b_spec)) begin
      spec_sign = 1'b0;
      spec_mant = 10'h3FF;
    end else if (b_zero) begin
      spec_dz   = !a_spec;
    end else if (a_spec) begin
      spec_dz   = 1'b0;
    end else if (a_zero || b_spec) begin
      spec_exp  = 5'd0;
    end else begin
      spec_hit  = 1'b0;
    end
  end

  assign ge     = rem >= {1'b0, dvs};
  assign r_next = ge ? (rem - {1'b0, dvs}) : rem;
  assign e_n    = q[11] ? e : (e - 7'sd1);
  assign m_n    = q[11] ? q[10:1] : q[9:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      sign          <= 1'b0;
      e             <= 7'sd0;
      rem           <= 12'd0;
      dvs           <= 11'd0;
      q             <= 12'd0;
      bus.out_valid <= 1'b0;
      bus.FinalSign <= 1'b0;
      bus.FinalExp  <= 5'd0;
      bus.FinalMant <= 10'd0;
      bus.overflow  <= 1'b0;
      bus.divzero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            sign <= s_in;
            e    <= e_in;
            rem  <= {2'b01, bus.Amant};
            dvs  <= {1'b1, bus.Bmant};
            q    <= 12'd0;
            cnt  <= 4'd0;
            if (spec_hit) begin
              bus.FinalSign <= spec_sign;
              bus.FinalExp  <= spec_exp;
              bus.FinalMant <= spec_mant;
              bus.overflow  <= (spec_exp == 5'd31);
              bus.divzero   <= spec_dz;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              state         <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          q   <= {q[10:0], ge};
          // r_next < divisor <= 2047, so the shift never loses a bit
          rem <= {r_next[10:0], 1'b0};
          if (cnt == 4'd11) begin
            cnt   <= 4'd0;
            state <= NORM;
          end else begin
            cnt   <= cnt + 4'd1;
          end
        end
        NORM: begin
          bus.FinalSign <= sign;
          bus.divzero   <= 1'b0;
          bus.out_valid <= 1'b1;
          if (e_n >= 7'sd31) begin
            bus.FinalExp  <= 5'd31;
            bus.FinalMant <= 10'd0;
            bus.overflow  <= 1'b1;
          end else if (e_n <= 7'sd0) begin
            bus.FinalExp  <= 5'd0;
            bus.FinalMant <= 10'd0;
            bus.overflow  <= 1'b0;
          end else begin
            bus.FinalExp  <= e_n[4:0];
            bus.FinalMant <= m_n;
            bus.overflow  <= 1'b0;
          end
          state <= DONE;
        end
        default: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_divider.sv
// tb/tb_fp16_divider.sv - scoreboard bench for fp16_divider with directed vectors
module tb_fp16_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_divider_if bus();
  fp16_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic       ovf;
    logic       dz;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_valid = 1'b0;
  logic [17:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && bus.out_valid) begin
      chk("in_ready_low_in_done", {31'd0, bus.in_ready}, 32'd0);
      if (!prev_valid) begin
        if (sb.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
        else chk("latency", cyc - sb[0].acc, sb[0].lat);
      end else begin
        chk("hold_stable", {14'd0, bus.FinalSign, bus.FinalExp, bus.FinalMant, bus.overflow, bus.divzero},
            {14'd0, held});
      end
      if (bus.out_ready && sb.size() > 0) begin
        x = sb.pop_front();
        chk("sign", {31'd0, bus.FinalSign}, {31'd0, x.s});
        chk("exp", {27'd0, bus.FinalExp}, {27'd0, x.e});
        chk("mant", {22'd0, bus.FinalMant}, {22'd0, x.m});
        chk("overflow", {31'd0, bus.overflow}, {31'd0, x.ovf});
        chk("divzero", {31'd0, bus.divzero}, {31'd0, x.dz});
      end
    end
    held       <= {bus.FinalSign, bus.FinalExp, bus.FinalMant, bus.overflow, bus.divzero};
    prev_valid <= rst_n && bus.out_valid;
  end

  task automatic issue(input logic as, input logic [4:0] ae, input logic [9:0] am,
                       input logic bs, input logic [4:0] be, input logic [9:0] bm,
                       input logic es, input logic [4:0] ee, input logic [9:0] em,
                       input logic eo, input logic ed, input int lat, input bit push);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      bus.Asign = as; bus.Aexp = ae; bus.Amant = am;
      bus.Bsign = bs; bus.Bexp = be; bus.Bmant = bm;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      // Scramble operands after the accept edge; the result must not notice.
      bus.Asign = ~as; bus.Aexp = ae ^ 5'h0A; bus.Amant = ~am;
      bus.Bsign = ~bs; bus.Bexp = be ^ 5'h05; bus.Bmant = ~bm;
      if (push) begin
        x.s = es; x.e = ee; x.m = em; x.ovf = eo; x.dz = ed; x.lat = lat; x.acc = cyc;
        sb.push_back(x);
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (sb.size() != 0 || bus.out_valid)}, 32'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.Asign = 1'b0; bus.Aexp = 5'd0; bus.Amant = 10'd0;
    bus.Bsign = 1'b0; bus.Bexp = 5'd0; bus.Bmant = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {14'd0, bus.out_valid, bus.FinalSign, bus.FinalExp, bus.FinalMant, bus.overflow, bus.divzero}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;

    issue(0, 15, 10'h000, 0, 15, 10'h000, 0, 15, 10'h000, 0, 0, 13, 1);  // 1/1
    issue(0, 16, 10'h200, 1, 16, 10'h000, 1, 15, 10'h200, 0, 0, 13, 1);  // 3/-2
    issue(0, 15, 10'h000, 0, 16, 10'h200, 0, 13, 10'h155, 0, 0, 13, 1);  // 1/3
    issue(0, 15, 10'h200, 0, 15, 10'h100, 0, 15, 10'h0CC, 0, 0, 13, 1);  // 1.5/1.25
    issue(0, 16, 10'h000, 0, 0, 10'h000, 0, 31, 10'h000, 1, 1, 0, 1);    // 2/0
    issue(0, 0, 10'h000, 0, 0, 10'h000, 0, 31, 10'h3FF, 1, 0, 0, 1);     // 0/0
    issue(0, 0, 10'h000, 0, 17, 10'h100, 0, 0, 10'h000, 0, 0, 0, 1);     // 0/5
    issue(0, 31, 10'h000, 0, 16, 10'h000, 0, 31, 10'h000, 1, 0, 0, 1);   // inf/2
    issue(1, 16, 10'h000, 0, 31, 10'h000, 1, 0, 10'h000, 0, 0, 0, 1);    // -2/inf
    issue(1, 30, 10'h000, 0, 1, 10'h000, 1, 31, 10'h000, 1, 0, 13, 1);   // exponent overflow
    issue(0, 1, 10'h000, 1, 30, 10'h000, 1, 0, 10'h000, 0, 0, 13, 1);    // exponent underflow
    drain();

    bus.out_ready = 1'b0;
    issue(0, 16, 10'h200, 1, 16, 10'h000, 1, 15, 10'h200, 0, 0, 13, 1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("backpressure_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    repeat (2) @(negedge clk);
    bus.Asign = 1'b0; bus.Aexp = 5'd16; bus.Amant = 10'd0;
    bus.Bsign = 1'b0; bus.Bexp = 5'd0; bus.Bmant = 10'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_consume", {31'd0, bus.in_ready}, 32'd1);
    issue(0, 15, 10'h000, 0, 16, 10'h200, 0, 13, 10'h155, 0, 0, 13, 1);
    drain();

    issue(0, 15, 10'h000, 0, 15, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {14'd0, bus.out_valid, bus.FinalSign, bus.FinalExp, bus.FinalMant, bus.overflow, bus.divzero}, 32'd0);
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      chk("no_output_after_abort", {31'd0, bus.out_valid}, 32'd0);
    end
    issue(0, 15, 10'h000, 0, 15, 10'h000, 0, 15, 10'h000, 0, 0, 13, 1);
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
